logic_exec_pipe: RTL
====================

Name: logic_exec_pipe

Overview:
- Registered logic-execution stage for the CPU15 datapath.
- Consumes operand pairs and an op code from the register-read stage and applies the bitwise function: AND and OR, the same primitives as the gate-level and_or cell, plus XOR, NOT, shifts and pass.
- Produces a result with flags to the write-back stage through a 2-stage valid/ready pipeline with full backpressure.
- Counts completed results for debug/perf.

Parameters:
- WIDTH, 16, operand/result width in bits (>=2).
- CNT_W, 8, width of completed-result counter.

Ports:
- clk  in  1  rising-edge clock.
- n_reset  in  1  asynchronous active-low reset.
- in_valid  in  1  operand/op presented.
- in_ready  out  1  stage 1 can accept this cycle.
- in_op  in  3  op code (see Behaviour).
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- out_valid  out  1  result presented.
- out_ready  in  1  downstream accepts.
- out_result  out  WIDTH  registered result.
- out_zero  out  1  result == 0.
- out_carry  out  1  bit shifted out (shifts only, else 0).
- done_cnt  out  CNT_W  number of accepted outputs, wraps.

Behaviour:
- Reset (n_reset low, asynchronous): all valid bits, out_result, out_zero, out_carry and done_cnt are 0. in_ready is 1 once reset is high, because the pipe is empty.
- Reset mid-operation: all in-flight data is discarded immediately. No output handshake completes in the reset cycle.
- Input transfer: occurs on a clock edge with in_valid & in_ready. Output transfer: occurs on out_valid & out_ready.
- Stage 1 (S1) registers in_op, in_a, in_b and v1. Stage 2 (S2) registers the computed result, flags and v2, which is out_valid.
- Advance rules:
  - adv2 = v1 & (!v2 | out_ready).
  - in_ready = !v1 | adv2, combinational from current state and out_ready.
  - S1 loads on input transfer. Otherwise v1 clears when adv2.
  - S2 loads on adv2. Otherwise v2 clears on output transfer.
- Latency: 2 clocks from input transfer to out_valid when out_ready stays high. Throughput: 1 per clock.
- Backpressure: with out_ready low and both stages full, in_ready is 0. out_result and the flags are held stable while out_valid & !out_ready.
- Simultaneous events: an output transfer, S1->S2 advance and new input load in the same cycle are all legal. No bubble is inserted.
- Op codes:
  - 000 A&B; 001 A|B; 010 A^B; 011 ~A.
  - 100 A<<1: carry = A[WIDTH-1], LSB filled with 0.
  - 101 A>>1, logical: carry = A[0], MSB filled with 0.
  - 110 pass B; 111 constant 0.
  - Carry is 0 for all non-shift ops. Result is truncated to WIDTH.
- out_zero is computed from the result in the same cycle it is registered, never from the previous value.
- done_cnt increments by 1 on each output transfer and wraps from 2^CNT_W-1 to 0. No other event changes it.
- in_op/in_a/in_b are ignored when in_valid is low. S1 contents are don't-care while v1 is 0.

Optional Feature:
- Macro: LOGIC_EXEC_PARITY_EN.
- Defined: adds output port out_parity (1 bit), the XOR-reduction of the registered result. It is registered alongside out_result, resets to 0 and is held under backpressure.
- Undefined: the port and its logic are absent. All other behaviour is unchanged.

Test Plan:
- Reset: hold n_reset low, then release with out_ready=1 -> out_valid=0, done_cnt=0, in_ready=1. Assert n_reset low asynchronously mid-clock with 2 items in flight -> out_valid drops to 0 without waiting for an edge, and done_cnt=0.
- Truth sweep: WIDTH=16, A=16'h00F0, B=16'h0F0F, ops 000..111 back-to-back, out_ready=1 -> results 0000, 0FFF, 0FFF, FF0F, 01E0, 0078, 0F0F, 0000, each 2 cycles after its input. zero=1 only for ops 000 and 111. carry=0 throughout.
- Shift boundaries: op 100 with A=16'h8001 -> result 0002, carry=1. Op 101 with A=16'h0001 -> result 0000, carry=1, zero=1.
- Backpressure: stream 4 items with out_ready=0 -> in_ready drops after 2 accepted, out_result holds the first item. Raise out_ready -> all 4 delivered in order on consecutive cycles, no loss or duplication.
- Counter wrap: CNT_W=8, 257 output transfers -> done_cnt=1. Toggling out_ready with out_valid=0 -> no increment.
- Parity (LOGIC_EXEC_PARITY_EN defined): op 110 with B=16'h0007 -> out_parity=1. With B=16'h0003 -> out_parity=0.

Source files
------------

// File: rtl/logic_exec_pipe.sv
// logic_exec_pipe: two-stage registered bitwise execution unit with
// valid/ready handshaking, result flags and a completed-result counter.
// Optional feature macro: LOGIC_EXEC_PARITY_EN adds out_parity.
module logic_exec_pipe #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_carry,
`ifdef LOGIC_EXEC_PARITY_EN
  output logic             out_parity,
`endif
  output logic [CNT_W-1:0] done_cnt
);

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_XOR  = 3'b010,
    OP_NOT  = 3'b011,
    OP_SHL  = 3'b100,
    OP_SHR  = 3'b101,
    OP_PASS = 3'b110,
    OP_ZERO = 3'b111
  } op_e;

  logic             v1_q, v1_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             v2_q, v2_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef LOGIC_EXEC_PARITY_EN
  logic             par_q, par_d;
`endif

  logic             adv2;
  logic             in_xfer;
  logic             out_xfer;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;

  // Bitwise function on the S1 operands; carry only meaningful for shifts.
  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    case (op_q)
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_XOR:  alu_res = a_q ^ b_q;
      OP_NOT:  alu_res = ~a_q;
      OP_SHL: begin
        alu_res   = {a_q[WIDTH-2:0], 1'b0};
        alu_carry = a_q[WIDTH-1];
      end
      OP_SHR: begin
        alu_res   = {1'b0, a_q[WIDTH-1:1]};
        alu_carry = a_q[0];
      end
      OP_PASS: alu_res = b_q;
      default: alu_res = '0;
    endcase
  end

  // Handshake/advance control and next-state for both stages and the counter.
  always_comb begin
    adv2     = v1_q & (~v2_q | out_ready);
    in_ready = ~v1_q | adv2;
    in_xfer  = in_valid & in_ready;
    out_xfer = v2_q & out_ready;

    v1_d    = v1_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    v2_d    = v2_q;
    res_d   = res_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
`ifdef LOGIC_EXEC_PARITY_EN
    par_d   = par_q;
`endif

    if (in_xfer) begin
      v1_d = 1'b1;
      op_d = op_e'(in_op);
      a_d  = in_a;
      b_d  = in_b;
    end else if (adv2) begin
      v1_d = 1'b0;
    end

    if (adv2) begin
      v2_d    = 1'b1;
      res_d   = alu_res;
      zero_d  = (alu_res == '0);
      carry_d = alu_carry;
`ifdef LOGIC_EXEC_PARITY_EN
      par_d   = ^alu_res;
`endif
    end else if (out_xfer) begin
      v2_d = 1'b0;
    end

    if (out_xfer) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Pipeline and counter registers; reset discards everything in flight.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      v1_q    <= 1'b0;
      op_q    <= OP_AND;
      a_q     <= '0;
      b_q     <= '0;
      v2_q    <= 1'b0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
`ifdef LOGIC_EXEC_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      v1_q    <= v1_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      v2_q    <= v2_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
`ifdef LOGIC_EXEC_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign out_valid  = v2_q;
  assign out_result = res_q;
  assign out_zero   = zero_q;
  assign out_carry  = carry_q;
  assign done_cnt   = cnt_q;
`ifdef LOGIC_EXEC_PARITY_EN
  assign out_parity = par_q;
`endif

endmodule
